// File: rtl/fft_bfly2_pipe.sv
// Radix-2 DIT butterfly, 3-stage elastic pipeline: y1 = x1 + x2*w', y2 = x1 - x2*w'.
// Each beat carries its own conj/scale/round modes; saturation raises a sticky flag.
module fft_bfly2_pipe #(
    parameter int DATA_INP_WD = 16,
    parameter int DATA_W_N_WD = 16,
    parameter int DATA_FRC_WD = 14,
    parameter int DATA_OUT_WD = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   val_i,
    output logic                   rdy_o,
    input  logic [DATA_INP_WD-1:0] dat_fft_1_re_i,
    input  logic [DATA_INP_WD-1:0] dat_fft_1_im_i,
    input  logic [DATA_INP_WD-1:0] dat_fft_2_re_i,
    input  logic [DATA_INP_WD-1:0] dat_fft_2_im_i,
    input  logic [DATA_W_N_WD-1:0] dat_wn_re_i,
    input  logic [DATA_W_N_WD-1:0] dat_wn_im_i,
    input  logic                   inv_i,
    input  logic                   scl_i,
    input  logic                   rnd_i,
    output logic                   val_o,
    input  logic                   rdy_i,
    output logic [DATA_OUT_WD-1:0] dat_fft_1_re_o,
    output logic [DATA_OUT_WD-1:0] dat_fft_1_im_o,
    output logic [DATA_OUT_WD-1:0] dat_fft_2_re_o,
    output logic [DATA_OUT_WD-1:0] dat_fft_2_im_o,
    output logic                   ovf_o,
    input  logic                   clr_ovf_i
);

    localparam int IW = DATA_INP_WD;
    localparam int WW = DATA_W_N_WD;
    localparam int FW = DATA_FRC_WD;
    localparam int OW = DATA_OUT_WD;
    localparam int STAGES = 3;
    // One extra bit so conj of the most negative twiddle stays exact
    localparam int PW = IW + WW + 1;
    localparam int AW = IW + FW;
    localparam int SW = ((PW > AW) ? PW : AW) + 2;

    localparam logic signed [SW-1:0] RND_HALF = {{(SW-1){1'b0}}, 1'b1} << (FW - 1);
    localparam logic signed [SW-1:0] SAT_MAX  = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN  = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic [STAGES:1] vld_pipe;
    logic            adv;

    // stage 1: operands and modes
    logic [IW-1:0] s1_x1re, s1_x1im, s1_x2re, s1_x2im;
    logic [WW-1:0] s1_wre, s1_wim;
    logic          s1_inv, s1_scl, s1_rnd;

    // stage 2: complex product and delayed x1
    logic [IW-1:0] s2_x1re, s2_x1im;
    logic [PW-1:0] s2_pre, s2_pim;
    logic          s2_scl, s2_rnd;

    logic signed [PW-1:0] x2re_e, x2im_e, wre_e, wim_e, wim_c, pre_c, pim_c;
    logic signed [SW-1:0] are_e, aim_e, pre_e, pim_e, t_c, r_c;
    logic signed [SW-1:0] sum_c [4];
    logic [3:0][OW-1:0]   res_c;
    logic [3:0]           sat_c;

    assign val_o = vld_pipe[STAGES];
    assign rdy_o = rdy_i || !val_o;
    assign adv   = rdy_o;

    always_comb begin
        x2re_e = PW'($signed(s1_x2re));
        x2im_e = PW'($signed(s1_x2im));
        wre_e  = PW'($signed(s1_wre));
        wim_e  = PW'($signed(s1_wim));
        wim_c  = s1_inv ? -wim_e : wim_e;
        pre_c  = x2re_e * wre_e - x2im_e * wim_c;
        pim_c  = x2re_e * wim_c + x2im_e * wre_e;
    end

    // Full-precision sums, then per-result round / shift / saturate
    always_comb begin
        are_e     = SW'($signed(s2_x1re)) <<< FW;
        aim_e     = SW'($signed(s2_x1im)) <<< FW;
        pre_e     = SW'($signed(s2_pre));
        pim_e     = SW'($signed(s2_pim));
        sum_c[0]  = are_e + pre_e;
        sum_c[1]  = aim_e + pim_e;
        sum_c[2]  = are_e - pre_e;
        sum_c[3]  = aim_e - pim_e;
        t_c       = '0;
        r_c       = '0;
        sat_c     = '0;
        res_c     = '0;
        for (int k = 0; k < 4; k++) begin
            t_c = sum_c[k] + (s2_rnd ? (RND_HALF <<< s2_scl) : SW'(0));
            r_c = s2_scl ? (t_c >>> (FW + 1)) : (t_c >>> FW);
            if (r_c > SAT_MAX) begin
                res_c[k] = SAT_MAX[OW-1:0];
                sat_c[k] = 1'b1;
            end else if (r_c < SAT_MIN) begin
                res_c[k] = SAT_MIN[OW-1:0];
                sat_c[k] = 1'b1;
            end else begin
                res_c[k] = r_c[OW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe       <= '0;
            s1_x1re        <= '0;
            s1_x1im        <= '0;
            s1_x2re        <= '0;
            s1_x2im        <= '0;
            s1_wre         <= '0;
            s1_wim         <= '0;
            s1_inv         <= 1'b0;
            s1_scl         <= 1'b0;
            s1_rnd         <= 1'b0;
            s2_x1re        <= '0;
            s2_x1im        <= '0;
            s2_pre         <= '0;
            s2_pim         <= '0;
            s2_scl         <= 1'b0;
            s2_rnd         <= 1'b0;
            dat_fft_1_re_o <= '0;
            dat_fft_1_im_o <= '0;
            dat_fft_2_re_o <= '0;
            dat_fft_2_im_o <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], val_i};
            s1_x1re  <= dat_fft_1_re_i;
            s1_x1im  <= dat_fft_1_im_i;
            s1_x2re  <= dat_fft_2_re_i;
            s1_x2im  <= dat_fft_2_im_i;
            s1_wre   <= dat_wn_re_i;
            s1_wim   <= dat_wn_im_i;
            s1_inv   <= inv_i;
            s1_scl   <= scl_i;
            s1_rnd   <= rnd_i;
            s2_x1re  <= s1_x1re;
            s2_x1im  <= s1_x1im;
            s2_pre   <= pre_c;
            s2_pim   <= pim_c;
            s2_scl   <= s1_scl;
            s2_rnd   <= s1_rnd;
            // bubbles leave the last result on the outputs
            if (vld_pipe[2]) begin
                dat_fft_1_re_o <= res_c[0];
                dat_fft_1_im_o <= res_c[1];
                dat_fft_2_re_o <= res_c[2];
                dat_fft_2_im_o <= res_c[3];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ovf_o <= 1'b0;
        else if (adv && vld_pipe[2] && |sat_c)
            ovf_o <= 1'b1;
        else if (clr_ovf_i)
            ovf_o <= 1'b0;
    end

endmodule

// File: tb/tb_fft_bfly2_pipe.sv
// Testbench for fft_bfly2_pipe: directed corner beats plus random streams under
// backpressure, checked against an integer-arithmetic butterfly model.
module tb_fft_bfly2_pipe;

    localparam int FRC = 14;

    logic clk = 1'b0, rstn = 1'b0;
    logic val_i = 1'b0, rdy_i = 1'b1, inv_i = 1'b0, scl_i = 1'b0, rnd_i = 1'b0, clr_ovf_i = 1'b0;
    logic rdy_o, val_o, ovf_o;
    logic [15:0] x1re_i = '0, x1im_i = '0, x2re_i = '0, x2im_i = '0, wre_i = '0, wim_i = '0;
    logic [15:0] y1re_o, y1im_o, y2re_o, y2im_o;

    int tests_run = 0, fails = 0;

    typedef struct {int x1re, x1im, x2re, x2im, wre, wim; bit inv, scl, rnd;} beat_t;
    typedef struct {int y1re, y1im, y2re, y2im; bit sat;} res_t;

    fft_bfly2_pipe dut (
        .clk(clk), .rstn(rstn), .val_i(val_i), .rdy_o(rdy_o),
        .dat_fft_1_re_i(x1re_i), .dat_fft_1_im_i(x1im_i),
        .dat_fft_2_re_i(x2re_i), .dat_fft_2_im_i(x2im_i),
        .dat_wn_re_i(wre_i), .dat_wn_im_i(wim_i),
        .inv_i(inv_i), .scl_i(scl_i), .rnd_i(rnd_i),
        .val_o(val_o), .rdy_i(rdy_i),
        .dat_fft_1_re_o(y1re_o), .dat_fft_1_im_o(y1im_o),
        .dat_fft_2_re_o(y2re_o), .dat_fft_2_im_o(y2im_o),
        .ovf_o(ovf_o), .clr_ovf_i(clr_ovf_i)
    );

    always #5 clk = ~clk;

    // floor(s / 2^S) or floor((s + 2^(S-1)) / 2^S), clamped to 16-bit signed
    function automatic int quant(input longint s, input bit scl, input bit rnd, output bit sat);
        longint d, q;
        d = 64'sd1 << (FRC + int'(scl));
        if (rnd) s = s + d / 2;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        sat = 1'b0;
        if (q > 32767) begin q = 32767; sat = 1'b1; end
        else if (q < -32768) begin q = -32768; sat = 1'b1; end
        return int'(q);
    endfunction

    function automatic res_t model(input beat_t b);
        longint wi, pr, pi, ar, ai;
        bit s0, s1, s2, s3;
        res_t r;
        wi = b.inv ? -longint'(b.wim) : longint'(b.wim);
        pr = longint'(b.x2re) * b.wre - longint'(b.x2im) * wi;
        pi = longint'(b.x2re) * wi + longint'(b.x2im) * b.wre;
        ar = longint'(b.x1re) * (64'sd1 << FRC);
        ai = longint'(b.x1im) * (64'sd1 << FRC);
        r.y1re = quant(ar + pr, b.scl, b.rnd, s0);
        r.y1im = quant(ai + pi, b.scl, b.rnd, s1);
        r.y2re = quant(ar - pr, b.scl, b.rnd, s2);
        r.y2im = quant(ai - pi, b.scl, b.rnd, s3);
        r.sat  = s0 | s1 | s2 | s3;
        return r;
    endfunction

    function automatic res_t observe();
        res_t r;
        r.y1re = int'($signed(y1re_o));
        r.y1im = int'($signed(y1im_o));
        r.y2re = int'($signed(y2re_o));
        r.y2im = int'($signed(y2im_o));
        r.sat  = ovf_o;
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.x1re = int'($urandom_range(0, 65535)) - 32768;
        b.x1im = int'($urandom_range(0, 65535)) - 32768;
        b.x2re = int'($urandom_range(0, 65535)) - 32768;
        b.x2im = int'($urandom_range(0, 65535)) - 32768;
        b.wre  = int'($urandom_range(0, 65535)) - 32768;
        b.wim  = int'($urandom_range(0, 65535)) - 32768;
        b.inv  = 1'($urandom_range(0, 1));
        b.scl  = 1'($urandom_range(0, 1));
        b.rnd  = 1'($urandom_range(0, 1));
        return b;
    endfunction

    function automatic beat_t mk(input int x1re, x1im, x2re, x2im, wre, wim, input bit inv, scl, rnd);
        beat_t b;
        b.x1re = x1re; b.x1im = x1im; b.x2re = x2re; b.x2im = x2im;
        b.wre = wre; b.wim = wim; b.inv = inv; b.scl = scl; b.rnd = rnd;
        return b;
    endfunction

    task automatic put_beat(input beat_t b);
        x1re_i = 16'(b.x1re); x1im_i = 16'(b.x1im);
        x2re_i = 16'(b.x2re); x2im_i = 16'(b.x2im);
        wre_i  = 16'(b.wre);  wim_i  = 16'(b.wim);
        inv_i = b.inv; scl_i = b.scl; rnd_i = b.rnd;
    endtask

    // Single beat with rdy_i=1; returns result seen at the first val_o and the latency
    task automatic send_one(input beat_t b, output res_t r, output int lat);
        @(negedge clk);
        put_beat(b);
        val_i = 1'b1;
        @(negedge clk);
        val_i = 1'b0;
        lat = 1;
        while (!val_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = observe();
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (val_o !== 1'b0 || ovf_o !== 1'b0 || rdy_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_ctrl: val_o=%b ovf_o=%b rdy_o=%b, want 0 0 1", val_o, ovf_o, rdy_o);
        end
        tests_run++;
        if ({y1re_o, y1im_o, y2re_o, y2im_o} !== 64'h0) begin
            fails++;
            $display("FAIL reset_data: got %h %h %h %h, want all 0", y1re_o, y1im_o, y2re_o, y2im_o);
        end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        res_t r;
        int lat;
        send_one(mk(100, 0, 50, 0, 16384, 0, 0, 0, 0), r, lat);
        tests_run++;
        if (lat !== 3) begin
            fails++;
            $display("FAIL basic_latency: got %0d cycles, want 3", lat);
        end
        tests_run++;
        if ({r.y1re, r.y1im, r.y2re, r.y2im} !== {32'sd150, 32'sd0, 32'sd50, 32'sd0} || r.sat !== 1'b0) begin
            fails++;
            $display("FAIL basic_value: got y1=(%0d,%0d) y2=(%0d,%0d) ovf=%b, want (150,0) (50,0) 0",
                     r.y1re, r.y1im, r.y2re, r.y2im, r.sat);
        end
        // bubble loads into stage 3 must not disturb the held outputs
        @(negedge clk);
        @(negedge clk);
        r = observe();
        tests_run++;
        if (val_o !== 1'b0 || r.y1re !== 150 || r.y2re !== 50) begin
            fails++;
            $display("FAIL bubble_hold: val_o=%b y1re=%0d y2re=%0d, want 0 150 50", val_o, r.y1re, r.y2re);
        end
    endtask

    task automatic test_rounding();
        res_t r;
        int lat;
        send_one(mk(0, 0, 1, 0, 8192, 0, 0, 0, 0), r, lat);
        tests_run++;
        if (r.y1re !== 0 || r.y2re !== -1 || lat !== 3) begin
            fails++;
            $display("FAIL round_floor: got y1re=%0d y2re=%0d lat=%0d, want 0 -1 3", r.y1re, r.y2re, lat);
        end
        send_one(mk(0, 0, 1, 0, 8192, 0, 0, 0, 1), r, lat);
        tests_run++;
        if (r.y1re !== 1 || r.y2re !== 0 || lat !== 3) begin
            fails++;
            $display("FAIL round_half_up: got y1re=%0d y2re=%0d lat=%0d, want 1 0 3", r.y1re, r.y2re, lat);
        end
    endtask

    task automatic test_saturation();
        res_t r;
        int lat;
        send_one(mk(30000, 0, 30000, 0, 16384, 0, 0, 0, 0), r, lat);
        tests_run++;
        if (r.y1re !== 32767 || r.y2re !== 0 || r.y1im !== 0 || ovf_o !== 1'b1) begin
            fails++;
            $display("FAIL sat_value: got y1re=%0d y2re=%0d y1im=%0d ovf=%b, want 32767 0 0 1",
                     r.y1re, r.y2re, r.y1im, ovf_o);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (ovf_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: got %b, want 1", ovf_o);
        end
        send_one(mk(30000, 0, 30000, 0, 16384, 0, 0, 1, 0), r, lat);
        tests_run++;
        if (r.y1re !== 30000 || r.y2re !== 0 || ovf_o !== 1'b1) begin
            fails++;
            $display("FAIL scale_value: got y1re=%0d y2re=%0d ovf=%b, want 30000 0 1", r.y1re, r.y2re, ovf_o);
        end
        @(negedge clk);
        clr_ovf_i = 1'b1;
        @(negedge clk);
        clr_ovf_i = 1'b0;
        tests_run++;
        if (ovf_o !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: got %b, want 0", ovf_o);
        end
        // clear held high while a saturating beat lands: set must win that cycle
        clr_ovf_i = 1'b1;
        send_one(mk(-30000, 0, 30000, 0, 16384, 0, 0, 0, 0), r, lat);
        tests_run++;
        if (ovf_o !== 1'b1 || r.y2re !== -32768) begin
            fails++;
            $display("FAIL ovf_set_wins: ovf=%b y2re=%0d, want 1 -32768", ovf_o, r.y2re);
        end
        @(negedge clk);
        tests_run++;
        if (ovf_o !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear_after: got %b, want 0", ovf_o);
        end
        clr_ovf_i = 1'b0;
    endtask

    task automatic test_inverse();
        res_t r;
        int lat;
        send_one(mk(0, 0, 100, 0, 0, -16384, 0, 0, 0), r, lat);
        tests_run++;
        if ({r.y1re, r.y1im, r.y2re, r.y2im} !== {32'sd0, -32'sd100, 32'sd0, 32'sd100}) begin
            fails++;
            $display("FAIL fwd_twiddle: got y1=(%0d,%0d) y2=(%0d,%0d), want (0,-100) (0,100)",
                     r.y1re, r.y1im, r.y2re, r.y2im);
        end
        send_one(mk(0, 0, 100, 0, 0, -16384, 1, 0, 0), r, lat);
        tests_run++;
        if ({r.y1re, r.y1im, r.y2re, r.y2im} !== {32'sd0, 32'sd100, 32'sd0, -32'sd100}) begin
            fails++;
            $display("FAIL inv_twiddle: got y1=(%0d,%0d) y2=(%0d,%0d), want (0,100) (0,-100)",
                     r.y1re, r.y1im, r.y2re, r.y2im);
        end
    endtask

    // Random beats; bp=1 randomizes val_i and rdy_i. Checks order, stability and rdy_o.
    task automatic test_stream(input int n, input bit bp);
        beat_t b;
        res_t q[$];
        res_t exp, got, prev;
        bit stalled = 1'b0;
        int sent = 0, rcvd = 0, cyc = 0;
        while ((sent < n || q.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                got = observe();
                tests_run++;
                if (val_o !== 1'b1 || {got.y1re, got.y1im, got.y2re, got.y2im} !==
                    {prev.y1re, prev.y1im, prev.y2re, prev.y2im}) begin
                    fails++;
                    $display("FAIL stall_hold: val_o=%b y1=(%0d,%0d) y2=(%0d,%0d), want held (%0d,%0d) (%0d,%0d)",
                             val_o, got.y1re, got.y1im, got.y2re, got.y2im,
                             prev.y1re, prev.y1im, prev.y2re, prev.y2im);
                end
            end
            rdy_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n && (!bp || $urandom_range(0, 3) != 0)) begin
                b = rand_beat();
                put_beat(b);
                val_i = 1'b1;
            end else begin
                val_i = 1'b0;
            end
            #1;
            tests_run++;
            if (rdy_o !== (rdy_i || !val_o)) begin
                fails++;
                $display("FAIL rdy_o: got %b with val_o=%b rdy_i=%b", rdy_o, val_o, rdy_i);
            end
            if (val_o && rdy_i) begin
                got = observe();
                tests_run++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: unexpected beat y1re=%0d", got.y1re);
                end else begin
                    exp = q.pop_front();
                    if ({got.y1re, got.y1im, got.y2re, got.y2im} !== {exp.y1re, exp.y1im, exp.y2re, exp.y2im}) begin
                        fails++;
                        $display("FAIL stream_beat%0d: got y1=(%0d,%0d) y2=(%0d,%0d), want (%0d,%0d) (%0d,%0d)",
                                 rcvd, got.y1re, got.y1im, got.y2re, got.y2im,
                                 exp.y1re, exp.y1im, exp.y2re, exp.y2im);
                    end
                end
                rcvd++;
            end
            if (val_i && rdy_o) begin
                q.push_back(model(b));
                sent++;
            end
            stalled = val_o && !rdy_i;
            prev = observe();
        end
        @(negedge clk);
        val_i = 1'b0;
        rdy_i = 1'b1;
        tests_run++;
        if (rcvd !== n || q.size() != 0) begin
            fails++;
            $display("FAIL stream_count: received %0d of %0d, %0d pending", rcvd, n, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        res_t r;
        int lat;
        bit leaked = 1'b0;
        send_one(mk(30000, 0, 30000, 0, 16384, 0, 0, 0, 0), r, lat);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            put_beat(mk(1000 + i, 7, 200, -3, 16384, 100, 0, 0, 0));
            val_i = 1'b1;
            @(negedge clk);
        end
        val_i = 1'b0;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (val_o !== 1'b0 || ovf_o !== 1'b0 || {y1re_o, y1im_o, y2re_o, y2im_o} !== 64'h0) begin
            fails++;
            $display("FAIL reset_async: val_o=%b ovf=%b data=%h %h %h %h, want all 0",
                     val_o, ovf_o, y1re_o, y1im_o, y2re_o, y2im_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (val_o) leaked = 1'b1;
        end
        tests_run++;
        if (leaked) begin
            fails++;
            $display("FAIL reset_stale: a discarded beat emerged after release");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_inverse();
        test_stream(20, 1'b0);
        test_stream(24, 1'b1);
        test_reset_midflight();
        test_basic();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
